// File: rtl/qed_dup_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qed_dup_sequencer
// Purpose  : QED duplication sequencer between fetch and decode. Issues each
//            original instruction unchanged while queueing it, then replays
//            the queued block as register/memory-remapped duplicates and
//            pulses qed_ready once every original has its duplicate issued.
// Revision : 1.0  initial release
// ============================================================================
module qed_dup_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             qed_mode,
    input  logic             qed_flush,
    input  logic [31:0]      ifu_inst,
    input  logic             ifu_valid,
    output logic             ifu_ready,
    output logic [31:0]      out_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_dup,
    output logic             qed_ready,
    output logic [CNT_W-1:0] pending_count
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]   c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   c_ONE      = CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [6:0]         c_OP_R     = 7'b0110011;
    localparam logic [6:0]         c_OP_I     = 7'b0010011;
    localparam logic [6:0]         c_OP_LW    = 7'b0000011;
    localparam logic [6:0]         c_OP_SW    = 7'b0100011;
    localparam logic [6:0]         c_OP_NOP   = 7'h7F;

    typedef enum logic [0:0] {
        ST_ORIG = 1'b0,
        ST_DUP  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_queue [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;

    logic               r_mode;
    logic               w_mode;

    logic [31:0]        r_out_inst;
    logic               r_out_valid;
    logic               r_out_dup;
    logic               r_out_last;
    logic               r_qed_ready;

    logic               w_load;
    logic               w_full;
    logic               w_empty;
    logic               w_is_nop;
    logic               w_ifu_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_ld_en;
    logic [31:0]        w_ld_inst;
    logic               w_ld_dup;
    logic               w_ld_last;
    logic [31:0]        w_dup_inst;

    // Remap x0-x15 to x16-x31 and shift memory offsets by +1024 (imm bit 10).
    function automatic logic [31:0] f_dup_xform(input logic [31:0] inst);
        logic [31:0] res;
        res = inst;
        case (inst[6:0])
            c_OP_R: begin
                res[11] = 1'b1;
                res[19] = 1'b1;
                res[24] = 1'b1;
            end
            c_OP_I: begin
                res[11] = 1'b1;
                res[19] = 1'b1;
            end
            c_OP_LW: begin
                res[11] = 1'b1;
                res[30] = 1'b1;
            end
            c_OP_SW: begin
                res[24] = 1'b1;
                res[30] = 1'b1;
            end
            default: res = inst;
        endcase
        return res;
    endfunction

    assign w_load     = !r_out_valid || out_ready;
    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_is_nop   = (ifu_inst[6:0] == c_OP_NOP);
    assign w_dup_inst = f_dup_xform(r_queue[r_rd_ptr]);
    // The mode input is transparent only while a new block may start.
    assign w_mode     = (r_state == ST_ORIG && w_empty) ? qed_mode : r_mode;

    // Next-state, fetch handshake, queue control and output-register load selection.
    always_comb begin
        w_state_nxt = r_state;
        w_ifu_ready = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ld_en     = 1'b0;
        w_ld_inst   = ifu_inst;
        w_ld_dup    = 1'b0;
        w_ld_last   = 1'b0;
        w_count_nxt = r_count;
        case (r_state)
            ST_ORIG: begin
                w_ifu_ready = reset_x && w_load && !w_full;
                // NOPs are consumed but neither issued nor queued.
                if (w_ifu_ready && ifu_valid && !w_is_nop) begin
                    w_ld_en   = 1'b1;
                    w_ld_inst = ifu_inst;
                    w_push    = w_mode;
                end
                w_count_nxt = r_count + CNT_W'(w_push);
                if (w_mode && ((w_count_nxt == c_DEPTH) ||
                               (qed_flush && (w_count_nxt != '0)))) begin
                    w_state_nxt = ST_DUP;
                end
            end
            ST_DUP: begin
                if (w_load && !w_empty) begin
                    w_pop       = 1'b1;
                    w_ld_en     = 1'b1;
                    w_ld_inst   = w_dup_inst;
                    w_ld_dup    = 1'b1;
                    w_ld_last   = (r_count == c_ONE);
                    w_count_nxt = r_count - c_ONE;
                    if (r_count == c_ONE) begin
                        w_state_nxt = ST_ORIG;
                    end
                end
            end
            default: w_state_nxt = ST_ORIG;
        endcase
    end

    // State, pointers, occupancy and latched mode.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            r_state  <= ST_ORIG;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_mode   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (r_state == ST_ORIG && w_empty) begin
                r_mode <= qed_mode;
            end
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_queue[r_wr_ptr] <= ifu_inst;
        end
    end

    // Output register and the block-complete pulse that follows the last duplicate.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            r_out_inst  <= '0;
            r_out_valid <= 1'b0;
            r_out_dup   <= 1'b0;
            r_out_last  <= 1'b0;
            r_qed_ready <= 1'b0;
        end else begin
            r_qed_ready <= r_out_valid && out_ready && r_out_last;
            if (w_load) begin
                r_out_valid <= w_ld_en;
                if (w_ld_en) begin
                    r_out_inst <= w_ld_inst;
                    r_out_dup  <= w_ld_dup;
                    r_out_last <= w_ld_last;
                end
            end
        end
    end

    assign ifu_ready     = w_ifu_ready;
    assign out_inst      = r_out_inst;
    assign out_valid     = r_out_valid;
    assign out_dup       = r_out_dup;
    assign qed_ready     = r_qed_ready;
    assign pending_count = r_count;

endmodule
`default_nettype wire

// File: doc/qed_dup_sequencer.md
# qed_dup_sequencer

Sits between the RIDECORE fetch output and the decoder for QED (quick error detection) checking. Issues each constrained original instruction unchanged and queues it. Then replays the queued block as duplicates: registers remapped from x0–x15 to x16–x31, memory addresses offset by +1024. Pulses `qed_ready` when every original in a block has a matching issued duplicate; the consistency checker samples that point.

## Interface
- `DEPTH`, default 8: maximum originals per block (duplicate queue entries).
- `CNT_W`, default 4: width of `pending_count`; must hold `DEPTH`.
- `clk`  in  1  clock.
- `reset_x`  in  1  synchronous active-low reset.
- `qed_mode`  in  1  1 = duplication enabled, 0 = pass-through.
- `qed_flush`  in  1  forces the current block to switch to duplicate issue.
- `ifu_inst`  in  32  instruction from fetch.
- `ifu_valid`  in  1  `ifu_inst` is valid.
- `ifu_ready`  out  1  the sequencer accepts `ifu_inst` this cycle.
- `out_inst`  out  32  instruction to decode.
- `out_valid`  out  1  `out_inst` is valid.
- `out_ready`  in  1  decode accepts `out_inst`.
- `out_dup`  out  1  `out_inst` is a duplicate.
- `qed_ready`  out  1  one-cycle pulse: block fully duplicated.
- `pending_count`  out  `CNT_W`  queued originals not yet duplicated.

## Operation
- Transfers:
  - Fetch transfer: `ifu_valid && ifu_ready`.
  - Output transfer: `out_valid && out_ready`.
  - The output register (`out_inst`, `out_valid`, `out_dup`) may load when `!out_valid || out_ready`.
- Mode latch:
  - `qed_mode` is latched only in state ORIG with the queue empty.
  - Otherwise the latched value is held.
- FSM state ORIG (reset state):
  - `ifu_ready = out-register-loadable && queue not full`.
  - On a fetch transfer, `ifu_inst` loads the output register with `out_dup=0`.
  - In QED mode, the fetch transfer also pushes `ifu_inst` to the queue.
  - NOP (opcode 7'h7F) is consumed (`ifu_ready` behaves normally) but not issued and not queued.
- ORIG → DUP: in QED mode, when either condition holds:
  - the queue is full after this cycle's push;
  - `qed_flush=1` and the queue is non-empty after this cycle's push.
  - A push and `qed_flush` in the same cycle: push first, then DUP.
  - `qed_flush` with the queue empty: ignored.
- FSM state DUP:
  - `ifu_ready=0`.
  - Whenever the output register is loadable, pop the queue head, transform it, and load it with `out_dup=1`.
  - On the pop that empties the queue, return to ORIG.
  - `qed_ready` pulses the cycle after the last duplicate's output transfer.
- Transform, by opcode:
  - 0110011 (R-type): set bit 4 of rd, rs1 and rs2 (inst[11], [19], [24]).
  - 0010011 (I-type): set inst[11] and inst[19]. The immediate/shamt field is unchanged.
  - 0000011 (LW): set inst[11] and inst[30] (imm +1024). rs1 stays 0.
  - 0100011 (SW): set inst[24] and inst[30] (imm +1024).
  - Any other opcode: unchanged.
- Pass-through (latched `qed_mode=0`):
  - The FSM stays in ORIG and nothing is queued.
  - `qed_ready` stays 0.
- Queue:
  - Circular buffer, read/write pointers wrap at `DEPTH`.
  - `pending_count` equals entries held, 0..`DEPTH`.
  - Order is preserved: duplicates issue in original order.

## Timing
- Reset (`reset_x=0` at a clock edge):
  - Outputs: `out_valid=0`, `out_inst=0`, `out_dup=0`, `qed_ready=0`, `pending_count=0`, `ifu_ready=0`.
  - Internal: FSM=ORIG, pointers=0.
  - Reset mid-block discards queued originals with no `qed_ready`.
- `ifu_ready` is 1 from the first cycle after reset deasserts, provided the output register is empty.
- Latency:
  - A fetch transfer at edge N makes `out_valid=1` after edge N.
  - The first duplicate loads at the edge after the transition into DUP, and then one per cycle while `out_ready=1`.
- Throughput: one instruction per cycle in either state with `out_ready` held at 1.
- Back-pressure: `out_ready=0` holds `out_inst`, `out_valid` and `out_dup` stable; no pop, no push.
- `qed_ready` is high for exactly one cycle per block, and never in the same cycle as `ifu_ready=1` of that block's DUP phase.

## Test plan
- Pass-through:
  - Stimulus: `qed_mode=0`, feed ADD x1,x2,x3 (0x003100B3).
  - Required: `out_inst=0x003100B3`, `out_dup=0`, `pending_count=0`, no `qed_ready`.
- Full block, `DEPTH=8`, `qed_mode=1`, `out_ready=1`:
  - Stimulus: 8 ADDI instructions.
  - Required: 8 originals, then `ifu_ready=0`; 8 duplicates with inst[11] and inst[19] set; `qed_ready` pulses once; `ifu_ready` returns to 1.
- Memory ops:
  - Stimulus: LW x5,4(x0) (0x00402283), SW x6,8(x0) (0x00602423), then `qed_flush`.
  - Required duplicates: 0x40402A83 and 0x41602423; `qed_ready` pulses after the second.
- Flush edge cases:
  - `qed_flush` with the queue empty → stays ORIG, no pulse.
  - `qed_flush` in the same cycle as a push → the pushed instruction is the last duplicate.
- Back-pressure and NOP:
  - Stimulus: `out_ready` toggling 1,0,0,1 during DUP, with a NOP (0x0000007F) mixed into ORIG.
  - Required: `out_inst` stable while stalled; the NOP never appears on the output; duplicate order matches original order.
- Reset mid-DUP:
  - Stimulus: assert `reset_x=0` with `pending_count=3`.
  - Required: `pending_count=0`, `out_valid=0`, FSM=ORIG, no `qed_ready` pulse.
